// File: rtl/mmm_serial_core.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod m, one bit of a per enabled cycle.
// Optional operand checking (err output, early DONE) is enabled by defining MMM_OPERAND_CHECK_EN.
module mmm_serial_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
`ifdef MMM_OPERAND_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_SUB  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rm;
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] acc_nxt;
    logic [WIDTH+1:0] sum_b;
    logic [WIDTH+1:0] sum_m;
    logic [WIDTH+1:0] acc_sub;
    logic [WIDTH-1:0] result_nxt;
    logic [CW-1:0]    cnt;
    logic             accept;

`ifdef MMM_OPERAND_CHECK_EN
    logic bad;
    logic bad_in;
    assign bad_in = (m[0] == 1'b0) || (a >= m) || (b >= m);
`endif

    assign accept = ((state == S_IDLE) || (state == S_DONE)) && start;

    // Datapath: acc stays below 2*rm, so WIDTH+2 bits never overflow.
    always_comb begin
        sum_b      = acc + (ra[cnt] ? {2'b00, rb} : '0);
        sum_m      = sum_b + (sum_b[0] ? {2'b00, rm} : '0);
        acc_nxt    = sum_m >> 1;
        acc_sub    = acc - {2'b00, rm};
        result_nxt = (acc >= {2'b00, rm}) ? acc_sub[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
`ifdef MMM_OPERAND_CHECK_EN
            S_LOAD:         state_nxt = bad ? S_DONE : S_ITER;
`else
            S_LOAD:         state_nxt = S_ITER;
`endif
            S_ITER:         if (cnt == CNT_LAST) state_nxt = S_SUB;
            S_SUB:          state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_LOAD) || (state == S_ITER) || (state == S_SUB);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            ra     <= '0;
            rb     <= '0;
            rm     <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
`ifdef MMM_OPERAND_CHECK_EN
            bad    <= 1'b0;
            err    <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        ra  <= a;
                        rb  <= b;
                        rm  <= m;
`ifdef MMM_OPERAND_CHECK_EN
                        bad <= bad_in;
                        err <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    acc <= '0;
                    cnt <= '0;
`ifdef MMM_OPERAND_CHECK_EN
                    if (bad) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
`endif
                end
                S_ITER: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                end
                S_SUB: begin
                    result <= result_nxt;
                end
                default: begin
                    result <= '0;
`ifdef MMM_OPERAND_CHECK_EN
                    err    <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmm_serial_core.sv
// Scoreboard bench for mmm_serial_core (WIDTH=8): directed operand vectors with hand-computed
// Montgomery products; a monitor pops the expected result whenever done rises.
module tb_mmm_serial_core;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [7:0] m = '0;
    logic [7:0] result;
    logic       busy;
    logic       done;
`ifdef MMM_OPERAND_CHECK_EN
    logic       err;
`endif

    int n_assert = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic done_q = 1'b0;

    mmm_serial_core #(.WIDTH(8)) dut (
        .clk    (clk),
        .rstb   (rstb),
        .ena    (ena),
        .start  (start),
        .a      (a),
        .b      (b),
        .m      (m),
        .result (result),
        .busy   (busy),
`ifdef MMM_OPERAND_CHECK_EN
        .err    (err),
`endif
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each rising done must match the oldest outstanding expected result.
    always @(negedge clk) begin
        done_q <= done;
        if (done === 1'b1 && done_q === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_done: got result %0d, expected no completion", result);
            end else begin
                check("result", {24'd0, result}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Issue one operation, then count edges after the capture edge until done.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] tm,
                          input logic [7:0] exp, input int exp_lat, input int stall_at,
                          input int stall_len, input bit junk_start, input string name);
        int k;
        exp_q.push_back(exp);
        a = ta; b = tb_v; m = tm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'hA5; b = 8'h3C; m = 8'h77;
        check({name, "_done_drop"}, {31'd0, done}, 32'd0);
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            check({name, "_busy"}, {31'd0, busy}, 32'd1);
            if (stall_len > 0 && k == stall_at) ena = 1'b0;
            if (stall_len > 0 && k == stall_at + stall_len) ena = 1'b1;
            if (junk_start) begin
                start = (k == 8);
                a = 8'd1; b = 8'd1; m = 8'd13;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        ena = 1'b1;
        check({name, "_latency"}, k, exp_lat);
        check({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
`ifdef MMM_OPERAND_CHECK_EN
        check({name, "_err"}, {31'd0, err}, (exp_lat == 1) ? 32'd1 : 32'd0);
`endif
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {24'd0, result}, 32'd0);
`ifdef MMM_OPERAND_CHECK_EN
        check("reset_err", {31'd0, err}, 32'd0);
`endif
        rstb = 1'b1;
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);

        run_op(8'd5,   8'd7,   8'd13,  8'd1, 10, 0, 0, 1'b0, "op_5_7");
        run_op(8'd1,   8'd1,   8'd13,  8'd3, 10, 0, 0, 1'b0, "op_1_1");
        run_op(8'd12,  8'd12,  8'd13,  8'd3, 10, 0, 0, 1'b0, "op_12_12");
        run_op(8'd254, 8'd254, 8'd255, 8'd1, 10, 0, 0, 1'b0, "op_254_254");
        run_op(8'd0,   8'd9,   8'd13,  8'd0, 10, 0, 0, 1'b0, "op_0_9");
        run_op(8'd5,   8'd7,   8'd13,  8'd1, 10, 0, 0, 1'b0, "op_restart");
        run_op(8'd5,   8'd7,   8'd13,  8'd1, 14, 3, 4, 1'b1, "op_stall");

        // Reset during ITER aborts the operation and clears the outputs.
        a = 8'd5; b = 8'd7; m = 8'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", {24'd0, result}, 32'd0);
        @(negedge clk);
        run_op(8'd1, 8'd1, 8'd13, 8'd3, 10, 0, 0, 1'b0, "op_after_reset");

`ifdef MMM_OPERAND_CHECK_EN
        run_op(8'd1,  8'd1, 8'd12, 8'd0, 1,  0, 0, 1'b0, "bad_even_m");
        run_op(8'd13, 8'd1, 8'd13, 8'd0, 1,  0, 0, 1'b0, "bad_a_ge_m");
        run_op(8'd5,  8'd7, 8'd13, 8'd1, 10, 0, 0, 1'b0, "good_after_bad");
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mmm_serial_core.md
Name: mmm_serial_core

Overview:
- Bit-serial Montgomery modular multiplier: result = A·B·2^(-WIDTH) mod M.
- It is the responder to the exponentiation control unit. That unit raises start (from its rst_mmm/ld_a phase) and waits on done before loading the result register.
- Processes one bit of A per enabled cycle, then applies one conditional final subtraction.
- Used for the map, square/multiply and remap operations of the RSA datapath.

Parameters:
- WIDTH, 8: operand and modulus width in bits. Also the iteration count. Legal values are 2..32.

Ports:
- clk  input  1  rising-edge clock
- rstb  input  1  reset, synchronous, active-low
- ena  input  1  global enable; when 0, all registers hold
- start  input  1  request a multiply; sampled only in IDLE or DONE
- a  input  WIDTH  multiplicand; captured at start
- b  input  WIDTH  multiplier; captured at start
- m  input  WIDTH  modulus; must be odd, with a<m and b<m; captured at start
- result  output  WIDTH  Montgomery product; valid while done=1
- busy  output  1  high in LOAD, ITER and SUB
- done  output  1  level; high in DONE until the next accepted start or reset

Behaviour:
- Reset: on a clk edge with rstb=0 (ena ignored), state=IDLE. Also cleared: result, busy, done, the internal acc, the bit counter, and the operand registers.
- Reset mid-operation aborts immediately. No partial result is retained.
- Every register update other than reset is qualified by ena=1.
- IDLE:
  - busy=0, done=0.
  - On start=1: capture a/b/m into ra/rb/rm, then go to LOAD.
- LOAD (1 cycle):
  - acc←0 (WIDTH+2 bits), cnt←0, busy=1.
  - Next state is ITER.
- ITER (WIDTH cycles):
  - s = acc + (ra[cnt] ? rb : 0).
  - q = s[0].
  - acc ← (s + (q ? rm : 0)) >> 1.
  - cnt←cnt+1.
  - When cnt==WIDTH-1, go to SUB.
  - Intermediate sums use WIDTH+2 bits, so no overflow is possible: acc<2M is invariant.
- SUB (1 cycle):
  - result ← (acc >= rm) ? acc-rm : acc, truncated to WIDTH bits.
  - Next state is DONE.
- DONE:
  - done=1, busy=0, result held.
  - start=1 recaptures operands and goes to LOAD. done drops on the same edge.
- Latency: start sampled on edge E0 gives done=1 after edge E0+WIDTH+2. For WIDTH=8 that is 10 cycles.
- start while busy is ignored. There is no queueing.
- ena=0 in any state freezes the state, counter, acc and outputs. Latency extends by the number of disabled cycles.
- a, b and m may change freely after the capture edge without affecting the operation.
- Operands violating the preconditions (m even, a≥m, b≥m) produce an unspecified result, but the timing is unchanged.
- Unused state encodings return to IDLE on the next enabled edge, with outputs at their reset values.

Optional Feature:
- Macro: MMM_OPERAND_CHECK_EN.
- When defined:
  - Adds output err (1 bit). It resets to 0 and is cleared on every accepted start.
  - At the capture edge the core checks m[0]==0, a≥m and b≥m. If any holds, the state goes directly to DONE on the next enabled edge, with result=0 and err=1.
  - Latency in that case is 1 cycle.
- When undefined:
  - The err port does not exist and no checking is done.
  - Timing is always WIDTH+2 cycles.

Test Plan:
- WIDTH=8, a=5, b=7, m=13, pulse start → done high exactly 10 cycles later, result=1, busy high for cycles 1–9.
- a=1, b=1, m=13 → result=3. a=12, b=12, m=13 → result=3. a=254, b=254, m=255 → result=1, which exercises the final subtraction path.
- a=0, b=9, m=13 → result=0. Then, with done held, start again with a=5, b=7 → done drops on the accepting edge and result=1 after 10 cycles.
- Start accepted; hold ena=0 for 4 cycles during ITER → done arrives at cycle 14, result unchanged (1 for 5·7 mod 13). A start pulse while busy has no effect.
- rstb=0 for one edge during ITER → next cycle state=IDLE, busy=0, done=0, result=0. A subsequent start completes normally.
- With MMM_OPERAND_CHECK_EN: m=12 or a=13 with m=13 → done=1 after 1 cycle, err=1, result=0. The next valid start clears err.
